// File: rtl/booth_mul_ctrl_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier sequencer.
package booth_mul_ctrl_pkg;

   localparam int MUL_XLEN = 64;
   localparam int MULW_LEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

   // mul_signed = {a_signed, b_signed}
   localparam int SGN_A_BIT = 1;
   localparam int SGN_B_BIT = 0;

   // One radix-4 digit per two bits of the extended operand
   localparam int ITERS_W = (MULW_LEN + 2) / 2;

   typedef struct packed {
      logic neg;
      logic pos;
      logic neg2;
      logic pos2;
   } booth_sel_t;

   function automatic int booth_iters(input int ext_width);
      return ext_width / 2;
   endfunction

   function automatic booth_sel_t booth_select(input logic [2:0] digit);
      booth_sel_t s;
      s = '0;
      case (digit)
         3'b001, 3'b010: s.pos  = 1'b1;
         3'b011:         s.pos2 = 1'b1;
         3'b100:         s.neg2 = 1'b1;
         3'b101, 3'b110: s.neg  = 1'b1;
         default:        s      = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/booth_mul_ctrl_pp.sv
// Radix-4 Booth partial product: {B[2:0], X} -> one of 0, +-X, +-2X.
module booth_pp_gen
   import booth_mul_ctrl_pkg::*;
#(
   parameter int XLEN = MUL_XLEN
) (
   input  logic [2:0]        digit,
   input  logic [2*XLEN-1:0] x,
   output logic [2*XLEN-1:0] pp
);

   booth_sel_t        sel;
   logic [2*XLEN-1:0] x2;

   assign sel = booth_select(digit);
   assign x2  = {x[2*XLEN-2:0], 1'b0};

   always_comb begin
      pp = '0;
      unique case (1'b1)
         sel.pos:  pp = x;
         sel.neg:  pp = -x;
         sel.pos2: pp = x2;
         sel.neg2: pp = -x2;
         default:  pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Iterative radix-4 Booth multiplier sequencer, one digit per cycle.
// Define MUL_EARLY_OUT_EN to finish as soon as the remaining digits are zero.
module booth_mul_ctrl
   import booth_mul_ctrl_pkg::*;
#(
   parameter int XLEN = MUL_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            mul_valid,
   output logic            mul_ready,
   input  logic            mulw,
   input  logic [1:0]      mul_signed,
   input  logic [XLEN-1:0] multiplicand,
   input  logic [XLEN-1:0] multiplier,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_hi,
   output logic [XLEN-1:0] result_lo
);

   localparam int PW = 2 * XLEN;
   localparam int EW = XLEN + 2;
   localparam int BW = EW + 1;
   localparam int CW = $clog2(EW + 1);

   mul_state_t      state_q, state_d;
   logic [PW-1:0]   acc_q, x_q, pp, acc_sum;
   logic [BW-1:0]   b_q;
   logic [CW-1:0]   cnt_q;
   logic            mulw_q;
   logic [XLEN-1:0] hi_q, lo_q;
   logic            a_sgn, b_sgn;
   logic [EW-1:0]   a_ext, b_ext;
   logic            load, step, fin, last, early;

   assign a_sgn = mul_signed[SGN_A_BIT];
   assign b_sgn = mul_signed[SGN_B_BIT];

   always_comb begin
      a_ext = {{2{a_sgn & multiplicand[XLEN-1]}}, multiplicand};
      b_ext = {{2{b_sgn & multiplier[XLEN-1]}}, multiplier};
      if (mulw) begin
         a_ext = {{(EW-MULW_LEN){a_sgn & multiplicand[MULW_LEN-1]}},
                  multiplicand[MULW_LEN-1:0]};
         b_ext = {{(EW-MULW_LEN){b_sgn & multiplier[MULW_LEN-1]}},
                  multiplier[MULW_LEN-1:0]};
      end
   end

   booth_pp_gen #(.XLEN(XLEN)) u_pp (
      .digit (b_q[2:0]),
      .x     (x_q),
      .pp    (pp)
   );

   assign acc_sum = acc_q + pp;

`ifdef MUL_EARLY_OUT_EN
   logic [BW-1:0] b_nxt;
   // Uniform remaining bits mean every later digit is 000 or 111
   assign b_nxt = {{2{b_q[BW-1]}}, b_q[BW-1:2]};
   assign early = (&b_nxt) | ~(|b_nxt);
`else
   assign early = 1'b0;
`endif

   assign last = (cnt_q == CW'(1)) | early;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (mul_valid) begin
               load    = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            step = 1'b1;
            if (last) begin
               fin     = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
         load    = 1'b0;
         step    = 1'b0;
         fin     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         x_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         mulw_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            acc_q  <= '0;
            x_q    <= {{(PW-EW){a_ext[EW-1]}}, a_ext};
            b_q    <= {b_ext, 1'b0};
            cnt_q  <= mulw ? CW'(ITERS_W) : CW'(booth_iters(EW));
            mulw_q <= mulw;
         end else if (step) begin
            acc_q <= acc_sum;
            x_q   <= {x_q[PW-3:0], 2'b00};
            b_q   <= {{2{b_q[BW-1]}}, b_q[BW-1:2]};
            cnt_q <= cnt_q - CW'(1);
         end
         if (fin) begin
            hi_q <= mulw_q ? {XLEN{acc_sum[MULW_LEN-1]}}
                           : acc_sum[PW-1:XLEN];
            lo_q <= mulw_q ? {{(XLEN-MULW_LEN){acc_sum[MULW_LEN-1]}},
                              acc_sum[MULW_LEN-1:0]}
                           : acc_sum[XLEN-1:0];
         end
      end
   end

   assign mul_ready = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result_hi = hi_q;
   assign result_lo = lo_q;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed bench for booth_mul_ctrl against a plain-arithmetic product model.
module tb_booth_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        mul_valid;
   logic        mul_ready;
   logic        mulw;
   logic [1:0]  mul_signed;
   logic [63:0] multiplicand;
   logic [63:0] multiplier;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result_hi;
   logic [63:0] result_lo;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic        exp_pending = 1'b0;
   logic [63:0] exp_hi = '0;
   logic [63:0] exp_lo = '0;

   booth_mul_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .mul_valid    (mul_valid),
      .mul_ready    (mul_ready),
      .mulw         (mulw),
      .mul_signed   (mul_signed),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result_hi    (result_hi),
      .result_lo    (result_lo)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] model(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [1:0]  sg,
                                          input logic        w);
      logic [127:0] ae, be, p;
      if (w) begin
         ae = {{96{sg[1] & a[31]}}, a[31:0]};
         be = {{96{sg[0] & b[31]}}, b[31:0]};
      end else begin
         ae = {{64{sg[1] & a[63]}}, a};
         be = {{64{sg[0] & b[63]}}, b};
      end
      p = ae * be;
      if (w) p = {{96{p[31]}}, p[31:0]};
      return p;
   endfunction

   // Last non-zero radix-4 digit of the extended multiplier sets the latency
   function automatic int early_lat(input logic [63:0] b,
                                    input logic [1:0]  sg,
                                    input logic        w);
      logic [66:0] br;
      int k, nd, d;
      if (w) br = {{34{sg[0] & b[31]}}, b[31:0], 1'b0};
      else   br = {{2{sg[0] & b[63]}}, b, 1'b0};
      nd = w ? 17 : 33;
      k  = 0;
      for (int i = 0; i < nd; i++) begin
         d = int'(br[2*i+1]) + int'(br[2*i]) - 2 * int'(br[2*i+2]);
         if (d != 0) k = i;
      end
      return k + 2;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
         n_chk++;
         if (!exp_pending) begin
            n_fail++;
            $display("FAIL stray_out_valid: got 1, expected 0");
         end else if (result_hi !== exp_hi || result_lo !== exp_lo) begin
            n_fail++;
            $display("FAIL result: got %h_%h, expected %h_%h",
                     result_hi, result_lo, exp_hi, exp_lo);
         end
      end
   end

   task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] sg, input logic w,
                        input logic [63:0] lhi, input logic [63:0] llo,
                        input int hold);
      logic [127:0] m;
      int n, lat;
      m = model(a, b, sg, w);
      chk("pin_hi", m[127:64], lhi);
      chk("pin_lo", m[63:0], llo);
      exp_hi      = m[127:64];
      exp_lo      = m[63:0];
      exp_pending = 1'b1;
`ifdef MUL_EARLY_OUT_EN
      lat = early_lat(b, sg, w);
`else
      lat = w ? 18 : 34;
`endif
      multiplicand = a;
      multiplier   = b;
      mul_signed   = sg;
      mulw         = w;
      out_ready    = (hold == 0);
      mul_valid    = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
         mul_valid = 1'b0;
         if (n == 1) chk("busy_ready", 64'(mul_ready), 64'd0);
      end while (!out_valid && n < 200);
      chk("latency", 64'(n), 64'(lat));
      mul_valid = (hold != 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_ready", 64'(mul_ready), 64'd0);
      end
      mul_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_pending = 1'b0;
      chk("release_valid", 64'(out_valid), 64'd0);
      chk("release_ready", 64'(mul_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      flush        = 1'b0;
      mul_valid    = 1'b0;
      mulw         = 1'b0;
      mul_signed   = 2'b00;
      multiplicand = '0;
      multiplier   = '0;
      out_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 64'(mul_ready), 64'd1);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_hi", result_hi, 64'd0);
      chk("rst_lo", result_lo, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op(64'd7, -64'sd3, 2'b11, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 0);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b10, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 5);
      do_op(64'h0000_0000_7FFF_FFFF, 64'd2, 2'b11, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0,
            64'd0, 64'h8000_0000_0000_0000, 0);
      do_op(64'd3, 64'd5, 2'b11, 1'b0, 64'd0, 64'd15, 0);
      do_op(64'd0, 64'h1234_5678_9ABC_DEF0, 2'b11, 1'b0, 64'd0, 64'd0, 0);
      do_op(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1,
            64'd0, 64'd1, 0);
      do_op(64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFF, 2'b11, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 3);

      // Abort a long operation mid-flight, then issue a fresh one
      multiplicand = 64'd123;
      multiplier   = 64'h7234_5678_9ABC_DEF0;
      mul_signed   = 2'b11;
      mulw         = 1'b0;
      mul_valid    = 1'b1;
      @(posedge clk);
      #1;
      mul_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush     = 1'b1;
      mul_valid = 1'b1;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      mul_valid = 1'b0;
      chk("flush_ready", 64'(mul_ready), 64'd1);
      chk("flush_valid", 64'(out_valid), 64'd0);
      do_op(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 2'b00, 1'b0,
            64'd1, 64'd0, 0);

      // Flush with a request in IDLE must not start anything
      flush     = 1'b1;
      mul_valid = 1'b1;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      mul_valid = 1'b0;
      chk("idle_flush_ready", 64'(mul_ready), 64'd1);
      repeat (40) @(posedge clk);
      #1;
      chk("idle_flush_quiet", 64'(out_valid), 64'd0);

      // Reset in the middle of an operation
      multiplicand = 64'd99;
      multiplier   = 64'h7000_0000_0000_0001;
      mul_signed   = 2'b11;
      mul_valid    = 1'b1;
      @(posedge clk);
      #1;
      mul_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 64'(mul_ready), 64'd1);
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_hi", result_hi, 64'd0);
      chk("midrst_lo", result_lo, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("midrst_quiet", 64'(out_valid), 64'd0);

      do_op(64'hFFFF_FFFF_FFFF_FFFE, 64'h4000_0000_0000_0000, 2'b11, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
